// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port synchronous memory between the instruction-fetch
//   requester (I, read-only) and the load/store requester (D, read/write).
//   D has priority, but a streak counter forces an I grant after
//   MAX_D_STREAK consecutive D grants made while I was waiting.
//   Only one transaction is in flight at a time. All MEM_* outputs, the ACKs
//   and the read-data ports are registered.
//
// Ports
//   CLK, RESET               clock (posedge) and synchronous active-high reset
//   I_REQ/I_ADDR             fetch request, held until I_ACK
//   I_ACK/I_RDATA            one-cycle done pulse and fetched word
//   D_REQ/D_WE/D_ADDR/D_WDATA load/store request, held until D_ACK
//   D_ACK/D_RDATA            one-cycle done pulse and load data (loads only)
//   MEM_EN/MEM_WE/MEM_ADDR/MEM_WDATA  memory strobe, write enable, address, data
//   MEM_RDATA                memory read data, valid MEM_LAT cycles after MEM_EN
//   BUSY                     high whenever the FSM is not idle
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LAT      = 1,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              I_REQ,
  input  logic [ADDR_W-1:0] I_ADDR,
  output logic              I_ACK,
  output logic [DATA_W-1:0] I_RDATA,
  input  logic              D_REQ,
  input  logic              D_WE,
  input  logic [ADDR_W-1:0] D_ADDR,
  input  logic [DATA_W-1:0] D_WDATA,
  output logic              D_ACK,
  output logic [DATA_W-1:0] D_RDATA,
  output logic              MEM_EN,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output logic              BUSY
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

  state_t              state_q;
  logic                own_d_q;     // 1: D owns the current transaction
  logic                we_q;        // current transaction is a store
  logic [2:0]          lat_cnt_q;
  logic [3:0]          streak_q;
  logic                i_ack_q;
  logic                d_ack_q;
  logic                mem_en_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [DATA_W-1:0]   i_rdata_q;
  logic [DATA_W-1:0]   d_rdata_q;

  logic                gnt_vld_d;
  logic                gnt_d_d;
  logic [3:0]          streak_d;

  // Grant decision. In IDLE both requesters compete; in RESP the owner that
  // is just being acknowledged is excluded so the other side gets a
  // back-to-back hand-off without passing through IDLE.
  always_comb begin
    gnt_vld_d = 1'b0;
    gnt_d_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        gnt_vld_d = I_REQ | D_REQ;
        gnt_d_d   = D_REQ && !(I_REQ && (streak_q == 4'(MAX_D_STREAK)));
      end
      ST_RESP: begin
        gnt_vld_d = own_d_q ? I_REQ : D_REQ;
        gnt_d_d   = !own_d_q;
      end
      default: begin
        gnt_vld_d = 1'b0;
        gnt_d_d   = 1'b0;
      end
    endcase

    // The streak only counts D grants that made a waiting I stand aside.
    streak_d = streak_q;
    if (gnt_vld_d) begin
      if (gnt_d_d && I_REQ) begin
        streak_d = (streak_q == 4'(MAX_D_STREAK)) ? streak_q : streak_q + 4'd1;
      end else begin
        streak_d = 4'd0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      own_d_q     <= 1'b0;
      we_q        <= 1'b0;
      lat_cnt_q   <= 3'd0;
      streak_q    <= 4'd0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      // Pulsed outputs default low; MEM_ADDR/MEM_WDATA hold their last value.
      i_ack_q  <= 1'b0;
      d_ack_q  <= 1'b0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_RESP: begin
          if (gnt_vld_d) begin
            // Request fields are captured here; later changes are ignored.
            state_q    <= ST_ISSUE;
            own_d_q    <= gnt_d_d;
            streak_q   <= streak_d;
            mem_en_q   <= 1'b1;
            mem_we_q   <= gnt_d_d & D_WE;
            we_q       <= gnt_d_d & D_WE;
            mem_addr_q <= gnt_d_d ? D_ADDR : I_ADDR;
            if (gnt_d_d) begin
              mem_wdata_q <= D_WDATA;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          state_q   <= ST_WAIT;
          lat_cnt_q <= 3'(MEM_LAT);
        end
        ST_WAIT: begin
          lat_cnt_q <= lat_cnt_q - 3'd1;
          if (lat_cnt_q == 3'd1) begin
            if (!we_q) begin
              if (own_d_q) begin
                d_rdata_q <= MEM_RDATA;
              end else begin
                i_rdata_q <= MEM_RDATA;
              end
            end
            if (own_d_q) begin
              d_ack_q <= 1'b1;
            end else begin
              i_ack_q <= 1'b1;
            end
            state_q <= ST_RESP;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign I_ACK     = i_ack_q;
  assign I_RDATA   = i_rdata_q;
  assign D_ACK     = d_ack_q;
  assign D_RDATA   = d_rdata_q;
  assign MEM_EN    = mem_en_q;
  assign MEM_WE    = mem_we_q;
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_WDATA = mem_wdata_q;
  assign BUSY      = (state_q != ST_IDLE);

endmodule
